// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline stage: a DEPTH-entry circular FIFO with valid/ready handshakes on both sides.
// Every output is a function of registered state only, so the stage fully breaks timing paths.
module pipe_stage_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              valid_last,
    output logic              ready_last,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_next,
    input  logic              ready_next,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;

    assign ready_last = (count_q < FULL_CNT);
    assign valid_next = (count_q != '0);
    assign count      = count_q;
    assign push       = valid_last & ready_last;
    assign pop        = valid_next & ready_next;

    // Pointers wrap explicitly so DEPTH need not be a power of two
    assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
    assign rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);

    // Stale array contents are masked here, so the array itself needs no reset
    assign data_out = valid_next ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: doc/pipe_stage_fifo.md
PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, meaning number of buffered entries (>=1, any integer, not restricted to powers of two).
REQ-003 SHALL have parameter CNT_W, default $clog2(DEPTH+1), meaning width of the occupancy output.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-006 SHALL have port flush, input, 1, synchronous kill of all buffered entries (branch/jump redirect).
REQ-007 SHALL have port valid_last, input, 1, meaning the upstream stage offers data_in.
REQ-008 SHALL have port ready_last, output, 1, meaning this stage accepts data_in this cycle.
REQ-009 SHALL have port data_in, input, DATA_W, the upstream payload.
REQ-010 SHALL have port valid_next, output, 1, meaning data_out holds a valid entry.
REQ-011 SHALL have port ready_next, input, 1, meaning the downstream stage consumes data_out this cycle.
REQ-012 SHALL have port data_out, output, DATA_W, the oldest buffered payload.
REQ-013 SHALL have port count, output, CNT_W, the current number of buffered entries (0..DEPTH).

Function
REQ-014 SHALL define push = valid_last & ready_last and pop = valid_next & ready_next, both evaluated in the same cycle.
REQ-015 SHALL drive ready_last = (count < DEPTH), derived from registered state only, with no combinational path from ready_next, valid_last or flush.
REQ-016 SHALL drive valid_next = (count != 0), derived from registered state only.
REQ-017 SHALL drive data_out from the entry at the read pointer when count != 0, and as all-zero when count == 0.
REQ-018 SHALL store data_in on push at the write pointer; the entry is visible on data_out no earlier than the following cycle, so minimum latency is 1 cycle and there is no data_in-to-data_out combinational path.
REQ-019 SHALL preserve FIFO order; payloads SHALL never be duplicated, dropped (except on flush) or reordered.
REQ-020 SHALL advance the write and read pointers by 1 on push and pop respectively, wrapping from DEPTH-1 to 0.
REQ-021 SHALL update the count as +1 for push only, -1 for pop only, and unchanged for push and pop together or for neither.
REQ-022 SHALL, when full (count == DEPTH), hold ready_last = 0 even if ready_next = 1 (no pass-through); DEPTH=1 therefore sustains at most 1 transfer per 2 cycles, and DEPTH>=2 sustains 1 per cycle.
REQ-023 SHALL, when empty, not pop; a push in that cycle yields valid_next = 1 on the next cycle.
REQ-024 SHALL give flush priority over everything: on the next edge count = 0, both pointers = 0, and any push or pop in the flush cycle has no effect on state.
REQ-025 SHALL still show ready_last and valid_next during a flush cycle per REQ-015/REQ-016; upstream must treat a flushed-cycle handshake as discarded.
REQ-026 SHALL hold data_out stable while valid_next = 1 and ready_next = 0, regardless of push.
REQ-027 SHALL not require storage-array contents to be reset; visibility of stale entries is prevented by REQ-017.

Reset
REQ-028 SHALL, while reset = 0, asynchronously force count = 0, both pointers = 0, valid_next = 0, data_out = 0 and ready_last = 1.
REQ-029 SHALL, if reset is asserted mid-operation, discard all entries immediately, without waiting for a clock edge.
REQ-030 SHALL take its first push on the first rising edge after reset deasserts, provided valid_last = 1.

Verification
REQ-031 SHALL cover streaming, DATA_W=32, DEPTH=2, ready_next=1: push 0x11, 0x22, 0x33 on consecutive cycles -> data_out shows 0x11, 0x22, 0x33 on cycles 1, 2, 3, ready_last stays 1, count stays <= 1.
REQ-032 SHALL cover backpressure, DEPTH=2, ready_next=0: push 0xA, 0xB -> count=2, ready_last=0, data_out=0xA held; then ready_next=1 for 2 cycles -> 0xA then 0xB, count returns to 0.
REQ-033 SHALL cover full with simultaneous pop: count=2, ready_next=1, valid_last=1 -> pop only, count=1 next cycle, and the offered data is not accepted until ready_last=1.
REQ-034 SHALL cover wrap-around, DEPTH=3: 10 random push/pop sequences with random backpressure -> output sequence equals input sequence and count never exceeds 3 or underflows.
REQ-035 SHALL cover flush: count=2 with a push and pop in the same cycle as flush=1 -> next cycle count=0, valid_next=0, data_out=0; the next pushed 0x55 appears alone.
REQ-036 SHALL cover async reset: with count=2, assert reset=0 between edges -> valid_next=0, count=0, data_out=0 before the next edge.
